solo_shot_gen: RTL and testbench
================================

# solo_shot_gen

Solo-mode shooter: on each round start, waits a programmable aiming delay counted in video frames, then draws a pseudo-random target inside the goal mouth from a free-running LFSR. It offers the target as `shot_xpos`/`shot_ypos` over a valid/ready handshake. It sits directly upstream of the goalkeeper/ball path (`gloves_control`, `ball_control`), replacing the human shooter when `solo_enable` is set, and tracks shots against a fixed series length.

## Interface
Parameters:
- `GOAL_X_MIN`, default 256: leftmost target x, pixels
- `GOAL_X_MAX`, default 767: rightmost target x; must be ≥ `GOAL_X_MIN`
- `GOAL_Y_MIN`, default 160: top target y
- `GOAL_Y_MAX`, default 415: bottom target y; must be ≥ `GOAL_Y_MIN`
- `AIM_FRAMES`, default 60: frame ticks between round start and shot
- `MAX_SHOTS`, default 5: shots per series, 1..15
- `SEED`, default 32'hACE1_2024: LFSR reset value; must be nonzero

Ports:
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `enable` in 1: solo mode active (driven from `solo_enable`)
- `frame_tick` in 1: one-cycle pulse per video frame
- `round_start` in 1: one-cycle pulse requesting the next shot
- `round_abort` in 1: cancel the current round
- `series_clear` in 1: reset shot counter and `series_done`
- `shot_ready` in 1: consumer accepts target
- `shot_valid` out 1: target available
- `shot_xpos` out 12: target x
- `shot_ypos` out 12: target y
- `busy` out 1: FSM not in IDLE
- `shot_count` out 4: completed handshakes in this series
- `series_done` out 1: `shot_count == MAX_SHOTS`

## Operation
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x^1, mask 32'h8020_0003. Shifts every cycle, independent of FSM state.
  - Reset loads `SEED`.
  - If the state ever reads 0, the next value is `SEED`.
- FSM states: IDLE, AIM, CALC, OFFER.
- IDLE → AIM: `round_start && enable && !series_done`. Frame counter loads `AIM_FRAMES`. Otherwise `round_start` is ignored.
- AIM: each `frame_tick` decrements the counter. When the counter is 0 (including `AIM_FRAMES = 0` on entry), go to CALC. A `frame_tick` in the same cycle as `round_start` is not counted.
- CALC, one cycle:
  - Sample `rx = lfsr[9:0]`, `ry = lfsr[25:16]`.
  - `shot_xpos <= GOAL_X_MIN + ((rx * (GOAL_X_MAX-GOAL_X_MIN+1)) >> 10)`, with a 23-bit product and truncation to 12 bits. `shot_ypos` is computed the same way from `ry`.
  - Result is always in [MIN, MAX]. Go to OFFER.
- OFFER:
  - `shot_valid` = 1. `shot_xpos`/`shot_ypos` hold stable until the handshake.
  - On `shot_valid && shot_ready`: `shot_count` +1, go to IDLE.
- `round_abort` in any non-IDLE state: go to IDLE next cycle, drop `shot_valid`, counter unchanged. Abort wins over a same-cycle handshake.
- `enable` deasserting mid-round has no effect; it gates only the start.
- `series_clear`: `shot_count <= 0`. If it coincides with a handshake, the result is 0. FSM state is unaffected.
- `rst`:
  - FSM → IDLE, LFSR → `SEED`.
  - `shot_valid`, `busy`, `series_done` = 0.
  - `shot_count` = 0.
  - `shot_xpos` = `GOAL_X_MIN`, `shot_ypos` = `GOAL_Y_MIN`.

## Timing
- `round_start` at cycle t → `busy` = 1 at t+1.
- Last needed `frame_tick` at cycle k → CALC at k+1, `shot_valid` at k+2. With `AIM_FRAMES = 0`: `shot_valid` at t+3.
- Handshake at cycle h → `shot_valid` = 0 and `shot_count` updated at h+1. `series_done` is registered from the new count at h+1. Earliest next accepted `round_start` is h+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- `game_pkg`: FSM state enum `shot_state_t`, default goal-mouth constants, LFSR mask constant. These are shared with `ball_control`/`gloves_control`.
- Sub-module `lfsr32`: ports `clk`, `rst`, `SEED` parameter, `q[31:0]`, with zero-lockup recovery.
- Top-level wiring: `shot_xpos`/`shot_ypos` are muxed with the mouse-driven shot by `enable` before `ball_control`.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs at reset values; `shot_xpos` = 256, `shot_ypos` = 160; LFSR = 32'hACE1_2024.
- `AIM_FRAMES = 3`, `round_start`, ticks every 10 cycles → `shot_valid` exactly 2 cycles after the 3rd tick. Coordinates must equal the bench LFSR model and lie within [256,767] × [160,415].
- Backpressure: `shot_ready` low for 20 cycles → `shot_valid` held, coordinates constant. Ready high 1 cycle → count 0→1, `shot_valid` low next cycle.
- Abort: `round_abort` during AIM and again during OFFER with `shot_ready` = 1 in the same cycle → IDLE, count unchanged, no valid pulse.
- Series: 5 full rounds → `series_done` = 1 and a 6th `round_start` is ignored (`busy` stays 0). `series_clear` → count 0, next `round_start` accepted.
- Edges: `enable` = 0 with `round_start` → no action. `AIM_FRAMES = 0` → valid at t+3. 10,000 random rounds → every coordinate within bounds.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared shooter FSM states, goal-mouth defaults and LFSR constants
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AIM   = 2'd1,
        ST_CALC  = 2'd2,
        ST_OFFER = 2'd3
    } shot_state_t;

    localparam int DEF_GOAL_X_MIN = 256;
    localparam int DEF_GOAL_X_MAX = 767;
    localparam int DEF_GOAL_Y_MIN = 160;
    localparam int DEF_GOAL_Y_MAX = 415;

    localparam logic [31:0] LFSR_MASK     = 32'h8020_0003;
    localparam logic [31:0] DEF_LFSR_SEED = 32'hACE1_2024;

    // Maps a 10-bit random value onto [lo, lo+span-1]; the >>10 keeps the result below lo+span.
    function automatic logic [11:0] scale_coord(input logic [9:0]  r,
                                                input logic [11:0] lo,
                                                input logic [12:0] span);
        logic [22:0] prod;
        prod = {13'd0, r} * {10'd0, span};
        return lo + prod[21:10];
    endfunction

endpackage

// File: rtl/lfsr32.sv
// rtl/lfsr32.sv - free-running 32-bit Galois LFSR with zero-state recovery
module lfsr32
    import game_pkg::*;
#(
    parameter logic [31:0] SEED = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] q
);

    logic [31:0] q_q;
    logic [31:0] q_d;

    always_comb begin
        q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_MASK : 32'd0);
        // An all-zero state would stick forever; reseed instead.
        if (q_q == 32'd0) begin
            q_d = SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/solo_shot_gen.sv
// rtl/solo_shot_gen.sv - solo-mode shooter: aim delay in frames, random target, valid/ready offer
module solo_shot_gen
    import game_pkg::*;
#(
    parameter int          GOAL_X_MIN = DEF_GOAL_X_MIN,
    parameter int          GOAL_X_MAX = DEF_GOAL_X_MAX,
    parameter int          GOAL_Y_MIN = DEF_GOAL_Y_MIN,
    parameter int          GOAL_Y_MAX = DEF_GOAL_Y_MAX,
    parameter int          AIM_FRAMES = 60,
    parameter int          MAX_SHOTS  = 5,
    parameter logic [31:0] SEED       = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic        round_start,
    input  logic        round_abort,
    input  logic        series_clear,
    input  logic        shot_ready,
    output logic        shot_valid,
    output logic [11:0] shot_xpos,
    output logic [11:0] shot_ypos,
    output logic        busy,
    output logic [3:0]  shot_count,
    output logic        series_done
);

    localparam logic [11:0] X_LO       = 12'(GOAL_X_MIN);
    localparam logic [11:0] Y_LO       = 12'(GOAL_Y_MIN);
    localparam logic [12:0] X_SPAN     = 13'(GOAL_X_MAX - GOAL_X_MIN + 1);
    localparam logic [12:0] Y_SPAN     = 13'(GOAL_Y_MAX - GOAL_Y_MIN + 1);
    localparam logic [15:0] AIM_LOAD   = 16'(AIM_FRAMES);
    localparam logic [3:0]  SHOTS_LAST = 4'(MAX_SHOTS);

    shot_state_t state_q, state_d;
    logic [15:0] aim_cnt_q, aim_cnt_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic [3:0]  count_q, count_d;
    logic        done_q, done_d;
    logic        handshake;
    logic [31:0] lfsr;
    logic        unused_lfsr_bits;

    lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign unused_lfsr_bits = ^{lfsr[31:26], lfsr[15:10]};

    always_comb begin
        state_d   = state_q;
        aim_cnt_d = aim_cnt_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        count_d   = count_q;
        handshake = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (round_start && enable && !done_q) begin
                    state_d   = ST_AIM;
                    aim_cnt_d = AIM_LOAD;
                end
            end
            ST_AIM: begin
                // The tick that takes the counter to zero leaves AIM in the same cycle.
                if (aim_cnt_q == 16'd0) begin
                    state_d = ST_CALC;
                end else if (frame_tick) begin
                    aim_cnt_d = aim_cnt_q - 16'd1;
                    if (aim_cnt_q == 16'd1) begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                xpos_d  = scale_coord(lfsr[9:0], X_LO, X_SPAN);
                ypos_d  = scale_coord(lfsr[25:16], Y_LO, Y_SPAN);
                state_d = ST_OFFER;
            end
            ST_OFFER: begin
                if (shot_ready) begin
                    handshake = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a same-cycle handshake.
        if (round_abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            handshake = 1'b0;
        end

        if (handshake) begin
            count_d = count_q + 4'd1;
        end
        if (series_clear) begin
            count_d = 4'd0;
        end

        valid_d = (state_d == ST_OFFER);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (count_d == SHOTS_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            aim_cnt_q <= 16'd0;
            xpos_q    <= X_LO;
            ypos_q    <= Y_LO;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= 4'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            aim_cnt_q <= aim_cnt_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

    assign shot_valid  = valid_q;
    assign shot_xpos   = xpos_q;
    assign shot_ypos   = ypos_q;
    assign busy        = busy_q;
    assign shot_count  = count_q;
    assign series_done = done_q;

endmodule

// File: tb/tb_solo_shot_gen.sv
// tb/tb_solo_shot_gen.sv - self-checking bench for solo_shot_gen
module tb_solo_shot_gen;

    localparam logic [31:0] SEED = 32'hACE1_2024;
    localparam logic [31:0] MASK = 32'h8020_0003;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;

    logic        tick = 1'b0, rs = 1'b0, ab = 1'b0, clr = 1'b0, rdy = 1'b0;
    logic        valid, busy, done;
    logic [11:0] xpos, ypos;
    logic [3:0]  cnt;

    logic        tick0 = 1'b0, rs0 = 1'b0, ab0 = 1'b0, clr0 = 1'b0, rdy0 = 1'b0;
    logic        valid0, busy0, done0;
    logic [11:0] xpos0, ypos0;
    logic [3:0]  cnt0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    solo_shot_gen #(.AIM_FRAMES(3)) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_tick(tick),
        .round_start(rs), .round_abort(ab), .series_clear(clr), .shot_ready(rdy),
        .shot_valid(valid), .shot_xpos(xpos), .shot_ypos(ypos),
        .busy(busy), .shot_count(cnt), .series_done(done)
    );

    solo_shot_gen #(.AIM_FRAMES(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .frame_tick(tick0),
        .round_start(rs0), .round_abort(ab0), .series_clear(clr0), .shot_ready(rdy0),
        .shot_valid(valid0), .shot_xpos(xpos0), .shot_ypos(ypos0),
        .busy(busy0), .shot_count(cnt0), .series_done(done0)
    );

    // Reference LFSR: value in the current cycle and in the previous one.
    logic [31:0] lfsr_m, lfsr_prev;
    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        if (rst)
            lfsr_m <= SEED;
        else if (lfsr_m == 32'd0)
            lfsr_m <= SEED;
        else
            lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? MASK : 32'd0);
    end

    typedef struct packed {
        logic en, rs, tick, ab, clr, rdy;
        logic e_valid, e_busy;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(input bit en_i, input bit rs_i, input bit tk_i, input bit ab_i,
                                input bit clr_i, input bit rdy_i, input bit ev, input bit eb,
                                input logic [3:0] ec);
        vec_t v;
        v.en = en_i; v.rs = rs_i; v.tick = tk_i; v.ab = ab_i; v.clr = clr_i; v.rdy = rdy_i;
        v.e_valid = ev; v.e_busy = eb; v.e_cnt = ec;
        return v;
    endfunction

    function automatic int scale(input int r, input int lo, input int hi);
        return lo + (r * (hi - lo + 1)) / 1024;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_coords(input string tag, input logic [11:0] xa, input logic [11:0] ya);
        int ex, ey;
        ex = scale(int'(lfsr_prev[9:0]), 256, 767);
        ey = scale(int'(lfsr_prev[25:16]), 160, 415);
        check({tag, "_x"}, 32'(xa), 32'(ex));
        check({tag, "_y"}, 32'(ya), 32'(ey));
        check({tag, "_bounds"}, 32'(xa >= 12'd256 && xa <= 12'd767 && ya >= 12'd160 && ya <= 12'd415), 32'd1);
    endtask

    task automatic round_dut();
        int w;
        rs = 1'b1; step(); rs = 1'b0;
        repeat (3) begin tick = 1'b1; step(); tick = 1'b0; end
        w = 0;
        while (!valid && w < 10) begin step(); w++; end
        check("round_valid", 32'(valid), 32'd1);
        rdy = 1'b1; step(); rdy = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          k_ok;
    logic [11:0] hx, hy;
    int          exp_cnt, w, dly;
    bit          c, hold_ok;

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) step();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_x", 32'(xpos), 32'd256);
        check("rst_y", 32'(ypos), 32'd160);
        check("rst_lfsr", dut.u_lfsr.q, SEED);
        rst = 1'b0;
        enable = 1'b1;
        step();

        // Zero aim delay: valid at t+3
        rs0 = 1'b1; step(); rs0 = 1'b0;
        check("z_busy_t1", 32'(busy0), 32'd1);
        step();
        check("z_valid_t2", 32'(valid0), 32'd0);
        step();
        check("z_valid_t3", 32'(valid0), 32'd1);
        check_coords("z", xpos0, ypos0);
        rdy0 = 1'b1; step(); rdy0 = 1'b0;
        check("z_cnt", 32'(cnt0), 32'd1);
        clr0 = 1'b1; step(); clr0 = 1'b0;
        check("z_clr", 32'(cnt0), 32'd0);

        // Cycle table: en rs tick ab clr rdy | valid busy cnt
        tbl[0]  = mk(L,H,L,L,L,L, L,L,4'd0);
        tbl[1]  = mk(H,L,L,L,L,L, L,L,4'd0);
        tbl[2]  = mk(H,H,L,L,L,L, L,H,4'd0);
        tbl[3]  = mk(H,L,H,L,L,L, L,H,4'd0);
        tbl[4]  = mk(H,L,L,L,L,L, L,H,4'd0);
        tbl[5]  = mk(H,L,L,H,L,L, L,L,4'd0);
        tbl[6]  = mk(H,H,H,L,L,L, L,H,4'd0);
        tbl[7]  = mk(H,L,H,L,L,L, L,H,4'd0);
        tbl[8]  = mk(H,L,H,L,L,L, L,H,4'd0);
        tbl[9]  = mk(L,L,L,L,L,L, L,H,4'd0);
        tbl[10] = mk(L,L,H,L,L,L, L,H,4'd0);
        tbl[11] = mk(H,L,L,L,L,L, H,H,4'd0);
        tbl[12] = mk(H,H,L,L,L,L, H,H,4'd0);
        tbl[13] = mk(H,L,L,H,L,H, L,L,4'd0);
        tbl[14] = mk(H,H,L,L,L,L, L,H,4'd0);
        tbl[15] = mk(H,L,H,L,L,L, L,H,4'd0);
        tbl[16] = mk(H,L,H,L,L,L, L,H,4'd0);
        tbl[17] = mk(H,L,H,L,L,L, L,H,4'd0);
        tbl[18] = mk(H,L,L,L,L,H, H,H,4'd0);
        tbl[19] = mk(H,L,L,L,L,H, L,L,4'd1);
        tbl[20] = mk(H,L,L,L,H,L, L,L,4'd0);
        tbl[21] = mk(H,H,L,L,L,L, L,H,4'd0);
        tbl[22] = mk(H,L,H,L,L,L, L,H,4'd0);
        tbl[23] = mk(H,L,H,L,L,L, L,H,4'd0);
        tbl[24] = mk(H,L,H,L,L,L, L,H,4'd0);
        tbl[25] = mk(H,L,L,L,L,L, H,H,4'd0);
        tbl[26] = mk(H,L,L,L,H,H, L,L,4'd0);
        tbl[27] = mk(H,L,L,L,L,L, L,L,4'd0);
        for (int i = 0; i < 28; i++) begin
            enable = tbl[i].en; rs = tbl[i].rs; tick = tbl[i].tick;
            ab = tbl[i].ab; clr = tbl[i].clr; rdy = tbl[i].rdy;
            step();
            check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
        end
        enable = 1'b1; rs = 1'b0; tick = 1'b0; ab = 1'b0; clr = 1'b0; rdy = 1'b0;

        // Ticks every 10 cycles: valid exactly 2 cycles after the third
        rs = 1'b1; step(); rs = 1'b0;
        k_ok = 1;
        for (int i = 0; i < 3; i++) begin
            repeat (9) begin
                step();
                if (valid !== 1'b0 || busy !== 1'b1) k_ok = 0;
            end
            tick = 1'b1; step(); tick = 1'b0;
        end
        check("aim_quiet", 32'(k_ok), 32'd1);
        check("aim_k1", 32'(valid), 32'd0);
        step();
        check("aim_k2", 32'(valid), 32'd1);
        check_coords("aim", xpos, ypos);

        // Backpressure
        hx = xpos; hy = ypos; hold_ok = 1'b1;
        repeat (20) begin
            step();
            if (valid !== 1'b1 || xpos !== hx || ypos !== hy) hold_ok = 1'b0;
        end
        check("bp_hold", 32'(hold_ok), 32'd1);
        rdy = 1'b1; step(); rdy = 1'b0;
        check("bp_cnt", 32'(cnt), 32'd1);
        check("bp_valid", 32'(valid), 32'd0);

        // Series of five, sixth start ignored, clear re-enables
        for (int i = 0; i < 4; i++) begin
            round_dut();
            check($sformatf("series_cnt%0d", i + 2), 32'(cnt), 32'(i + 2));
        end
        check("series_done", 32'(done), 32'd1);
        rs = 1'b1; step(); rs = 1'b0;
        check("sixth_busy_a", 32'(busy), 32'd0);
        step();
        check("sixth_busy_b", 32'(busy), 32'd0);
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_cnt", 32'(cnt), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        rs = 1'b1; step(); rs = 1'b0;
        check("clr_start", 32'(busy), 32'd1);
        ab = 1'b1; step(); ab = 1'b0;
        check("clr_abort", 32'(busy), 32'd0);

        // Random rounds on the zero-delay instance
        exp_cnt = 0;
        for (int r = 0; r < 10000; r++) begin
            if (exp_cnt == 5) begin
                check("rnd_done", 32'(done0), 32'd1);
                clr0 = 1'b1; step(); clr0 = 1'b0;
                exp_cnt = 0;
                check("rnd_clr", 32'(cnt0), 32'd0);
            end
            rs0 = 1'b1; step(); rs0 = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                ab0 = 1'b1; rdy0 = 1'($urandom_range(0, 1)); step(); ab0 = 1'b0; rdy0 = 1'b0;
                check("rnd_abort_busy", 32'(busy0), 32'd0);
                check("rnd_abort_cnt", 32'(cnt0), 32'(exp_cnt));
                continue;
            end
            w = 0;
            while (!valid0 && w < 8) begin step(); w++; end
            check("rnd_valid", 32'(valid0), 32'd1);
            check_coords("rnd", xpos0, ypos0);
            hx = xpos0; hy = ypos0; hold_ok = 1'b1;
            dly = $urandom_range(0, 2);
            repeat (dly) begin
                step();
                if (valid0 !== 1'b1 || xpos0 !== hx || ypos0 !== hy) hold_ok = 1'b0;
            end
            if (dly != 0) check("rnd_hold", 32'(hold_ok), 32'd1);
            c = ($urandom_range(0, 9) == 0);
            rdy0 = 1'b1; clr0 = c; step(); rdy0 = 1'b0; clr0 = 1'b0;
            exp_cnt = c ? 0 : exp_cnt + 1;
            check("rnd_cnt", 32'(cnt0), 32'(exp_cnt));
            check("rnd_valid_drop", 32'(valid0), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
